// File: rtl/rip_uart_tx_mmio.sv
// rtl/rip_uart_tx_mmio.sv - memory-mapped 8N1 UART transmitter with TX FIFO
// Decodes MA-stage loads/stores in a 16-byte window; RDATA has data-RAM (1-cycle) latency.
module rip_uart_tx_mmio #(
  parameter logic [31:0] BASE_ADDR   = 32'hF000_0000,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        MA_READY,
  input  logic        WE,
  input  logic        RE,
  input  logic [31:0] ADDR,
  input  logic [31:0] WDATA,
  output logic [31:0] RDATA,
  output logic        TX,
  output logic        IRQ_EMPTY
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic          hit, wr, rd;
  logic [1:0]    off;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic          ovf;
  logic [15:0]   div;
  logic          full, empty, busy;
  logic          push_req, push_ok, pop;
  logic [31:0]   rd_val;
  state_t        state, state_nxt;
  logic [15:0]   bit_cnt, bit_cnt_nxt;
  logic [2:0]    bit_idx, bit_idx_nxt;
  logic [7:0]    shift, shift_nxt;
  logic          bit_end;
  logic          unused_bits;

  assign hit      = MA_READY && (ADDR[31:4] == BASE_ADDR[31:4]);
  assign off      = ADDR[3:2];
  assign wr       = hit && WE;
  assign rd       = hit && RE;
  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign busy     = (state != IDLE);
  assign push_req = wr && (off == 2'd0);
  // A full FIFO still accepts a byte when the serializer pops in the same cycle.
  assign push_ok  = push_req && (!full || pop);
  assign bit_end  = (bit_cnt == 16'd0);
  assign IRQ_EMPTY = empty && !busy;
  assign unused_bits = ^{ADDR[1:0], WDATA[31:16]};

  always_comb begin
    rd_val = '0;
    case (off)
      2'd1:    rd_val = {28'd0, ovf, busy, empty, full};
      2'd2:    rd_val = {16'd0, div};
      default: rd_val = '0;
    endcase
  end

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift;
    pop         = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) pop = 1'b1;
      end
      START: begin
        if (bit_end) begin
          state_nxt   = DATA;
          bit_idx_nxt = 3'd0;
          bit_cnt_nxt = div - 16'd1;
        end else begin
          bit_cnt_nxt = bit_cnt - 16'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          bit_cnt_nxt = div - 16'd1;
          if (bit_idx == 3'd7) begin
            state_nxt = STOP;
          end else begin
            bit_idx_nxt = bit_idx + 3'd1;
            shift_nxt   = shift >> 1;
          end
        end else begin
          bit_cnt_nxt = bit_cnt - 16'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (!empty) pop = 1'b1;
          else        state_nxt = IDLE;
        end else begin
          bit_cnt_nxt = bit_cnt - 16'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Popping always starts a fresh frame, from IDLE or straight out of STOP.
    if (pop) begin
      state_nxt   = START;
      shift_nxt   = mem[rptr];
      bit_cnt_nxt = div - 16'd1;
    end
  end

  always_comb begin
    TX = 1'b1;
    case (state)
      START:   TX = 1'b0;
      DATA:    TX = shift[0];
      default: TX = 1'b1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state   <= IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      bit_idx <= bit_idx_nxt;
      shift   <= shift_nxt;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ovf   <= 1'b0;
      div   <= DEFAULT_DIV;
      RDATA <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
      count <= count + CW'(push_ok) - CW'(pop);
      // A dropped byte sets ovf even if STATUS is being cleared.
      if (push_req && !push_ok)
        ovf <= 1'b1;
      else if (wr && off == 2'd1 && WDATA[3])
        ovf <= 1'b0;
      if (wr && off == 2'd2)
        div <= (WDATA[15:0] == 16'd0) ? 16'd1 : WDATA[15:0];
      if (rd) RDATA <= rd_val;
    end
  end

  always_ff @(posedge CLK) begin
    if (push_ok) mem[wptr] <= WDATA[7:0];
  end

endmodule

// File: tb/tb_rip_uart_tx_mmio.sv
// tb/tb_rip_uart_tx_mmio.sv - directed and randomized bench for rip_uart_tx_mmio
module tb_rip_uart_tx_mmio;
  localparam logic [31:0] BASE  = 32'hF000_0000;
  localparam int          DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n, ma_ready, we, re;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        tx, irq_empty;

  always #5 clk = ~clk;

  rip_uart_tx_mmio #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .DEFAULT_DIV(16'd868)) dut (
    .CLK(clk), .RST_N(rst_n), .MA_READY(ma_ready), .WE(we), .RE(re),
    .ADDR(addr), .WDATA(wdata), .RDATA(rdata), .TX(tx), .IRQ_EMPTY(irq_empty)
  );

  int n_err = 0;
  int n_checks = 0;

  // Reference model: byte queue plus a frame position 0..9 (start, 8 data, stop).
  logic [7:0]  m_q[$];
  bit          m_busy;
  int          m_pos, m_left;
  logic [7:0]  m_cur;
  logic [15:0] m_div;
  bit          m_ovf;
  logic [31:0] m_rdata;

  function automatic logic m_tx();
    if (!m_busy) return 1'b1;
    if (m_pos == 0) return 1'b0;
    if (m_pos == 9) return 1'b1;
    return m_cur[m_pos-1];
  endfunction

  task automatic m_step();
    int cnt;
    bit hit, pop, dropped;
    logic [1:0] o;
    cnt = m_q.size();
    pop = 0;
    dropped = 0;
    if (!rst_n) begin
      m_q.delete(); m_busy = 0; m_pos = 0; m_left = 0;
      m_ovf = 0; m_div = 16'd868; m_rdata = 0;
      return;
    end
    hit = ma_ready && (addr[31:4] == BASE[31:4]);
    o = addr[3:2];
    if (hit && re) begin
      case (o)
        2'd1:    m_rdata = {28'd0, m_ovf, m_busy, cnt == 0, cnt == DEPTH};
        2'd2:    m_rdata = {16'd0, m_div};
        default: m_rdata = 32'd0;
      endcase
    end
    if (!m_busy) begin
      if (cnt > 0) pop = 1;
    end else if (m_left == 0) begin
      if (m_pos == 9) begin
        if (cnt > 0) pop = 1; else m_busy = 0;
      end else begin
        m_pos++;
        m_left = int'(m_div) - 1;
      end
    end else begin
      m_left--;
    end
    if (pop) begin
      m_cur = m_q.pop_front();
      m_busy = 1; m_pos = 0; m_left = int'(m_div) - 1;
    end
    if (hit && we) begin
      case (o)
        2'd0: if (cnt < DEPTH || pop) m_q.push_back(wdata[7:0]); else dropped = 1;
        2'd1: if (wdata[3]) m_ovf = 0;
        2'd2: m_div = (wdata[15:0] == 16'd0) ? 16'd1 : wdata[15:0];
        default: ;
      endcase
    end
    if (dropped) m_ovf = 1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    m_step();
    @(posedge clk);
    #1;
    chk("tx", 32'(tx), 32'(m_tx()));
    chk("irq_empty", 32'(irq_empty), 32'(m_q.size() == 0 && !m_busy));
    chk("rdata", rdata, m_rdata);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    ma_ready = 1; we = 1; re = 0; addr = a; wdata = d;
    tick();
    ma_ready = 0; we = 0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    ma_ready = 1; we = 0; re = 1; addr = a;
    tick();
    v = rdata;
    ma_ready = 0; re = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  initial begin
    logic [31:0] v;
    logic [9:0]  f1;
    logic [19:0] f2;
    logic [1:0]  o;

    rst_n = 0; ma_ready = 0; we = 0; re = 0; addr = 0; wdata = 0;
    idle(2);
    rst_n = 1;
    chk("reset_tx", 32'(tx), 32'd1);
    chk("reset_irq", 32'(irq_empty), 32'd1);
    chk("reset_rdata", rdata, 32'd0);
    rd(BASE + 4, v); chk("reset_status", v, 32'h2);
    rd(BASE + 8, v); chk("reset_div", v, 32'd868);

    // Single 0x55 frame at DIV=4
    wr(BASE + 8, 32'd4);
    wr(BASE + 0, 32'h55);
    idle(1);
    f1 = {1'b1, 8'h55, 1'b0};
    for (int i = 0; i < 40; i++) begin
      chk("frame55", 32'(tx), 32'(f1[i/4]));
      tick();
    end
    chk("frame55_end_irq", 32'(irq_empty), 32'd1);

    // Fill and overflow the FIFO
    wr(BASE + 8, 32'd3);
    for (int i = 0; i < 9; i++) wr(BASE + 0, $urandom);
    rd(BASE + 4, v); chk("status_full_no_ovf", v, 32'h5);
    for (int i = 0; i < 10; i++) wr(BASE + 0, $urandom);
    rd(BASE + 4, v); chk("status_ovf", v, 32'hD);
    wr(BASE + 4, 32'h8);
    rd(BASE + 4, v); chk("status_ovf_clr", v, 32'h5);
    for (int k = 0; k < 3000 && !irq_empty; k++) tick();
    chk("drain_irq", 32'(irq_empty), 32'd1);

    // Back-to-back frames at DIV=1
    wr(BASE + 8, 32'd1);
    wr(BASE + 0, 32'hA5);
    wr(BASE + 0, 32'h3C);
    f2 = {1'b1, 8'h3C, 1'b0, 1'b1, 8'hA5, 1'b0};
    for (int i = 0; i < 20; i++) begin
      chk("b2b", 32'(tx), 32'(f2[i]));
      tick();
    end
    chk("b2b_end_irq", 32'(irq_empty), 32'd1);

    // DIV=0 clamps, misses are ignored, read-during-write returns old value
    wr(BASE + 8, 32'd0);
    rd(BASE + 8, v); chk("div_zero", v, 32'd1);
    ma_ready = 1; we = 1; re = 1; addr = BASE + 32'h18; wdata = 32'd7; tick();
    chk("miss_0x10", rdata, 32'd1);
    addr = 32'h0000_8008; tick();
    chk("miss_0x8000", rdata, 32'd1);
    ma_ready = 0; addr = BASE + 8; tick();
    chk("miss_not_ready", rdata, 32'd1);
    ma_ready = 1; wdata = 32'd3; tick();
    chk("rw_same_old", rdata, 32'd1);
    ma_ready = 0; we = 0; re = 0;
    rd(BASE + 8, v); chk("rw_same_new", v, 32'd3);
    rd(BASE + 4, v); chk("miss_status", v, 32'h2);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      ma_ready = ($urandom_range(0, 9) != 0);
      we = 1'($urandom_range(0, 1));
      re = 1'($urandom_range(0, 1));
      o = 2'($urandom_range(0, 3));
      addr = BASE | {28'd0, o, 2'b00} | 32'($urandom_range(0, 3));
      wdata = $urandom;
      if (o == 2'd2) wdata[15:0] = 16'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) addr = 32'h0000_8004;
      tick();
    end
    ma_ready = 0; we = 0; re = 0;
    wr(BASE + 4, 32'h8);

    // Reset during bit 3 of a frame with three bytes queued
    wr(BASE + 8, 32'd2);
    for (int k = 0; k < 3000 && !irq_empty; k++) tick();
    wr(BASE + 0, 32'h96);
    wr(BASE + 0, 32'h5A);
    wr(BASE + 0, 32'hC3);
    idle(7);
    rst_n = 0;
    tick();
    rst_n = 1;
    chk("rst_mid_tx", 32'(tx), 32'd1);
    rd(BASE + 4, v); chk("rst_mid_status", v, 32'h2);
    idle(60);
    chk("rst_mid_quiet_tx", 32'(tx), 32'd1);
    chk("rst_mid_quiet_irq", 32'(irq_empty), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
